// File: rtl/vram_pattern_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_pattern_loader_if : VRAM port bundle between the loader and the GPU
// Revision 1.0
// ---------------------------------------------------------------------------
interface vram_pattern_loader_if;
  logic [1:0]  I_VIDEO_MODE;
  logic [7:0]  I_VRAM_DATA;
  logic        O_MEM_ENABLE;
  logic        O_VRAM_WE_L;
  logic        O_VRAM_RE_L;
  logic [15:0] O_VRAM_ADDR;
  logic [7:0]  O_VRAM_DATA;

  modport master (
    input  I_VIDEO_MODE, I_VRAM_DATA,
    output O_MEM_ENABLE, O_VRAM_WE_L, O_VRAM_RE_L, O_VRAM_ADDR, O_VRAM_DATA
  );

  modport slave (
    output I_VIDEO_MODE, I_VRAM_DATA,
    input  O_MEM_ENABLE, O_VRAM_WE_L, O_VRAM_RE_L, O_VRAM_ADDR, O_VRAM_DATA
  );
endinterface
`default_nettype wire

// File: rtl/vram_pattern_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vram_pattern_loader : fills a VRAM window with a seeded pattern, reads it back
// Revision 1.0
// ---------------------------------------------------------------------------
module vram_pattern_loader #(
  parameter logic [15:0] START_ADDR   = 16'h8000,
  parameter logic [15:0] LENGTH       = 16'h2000,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter int          READ_LATENCY = 2
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET_L,
  input  logic                         I_START,
  vram_pattern_loader_if.master        vram,
  output logic                         O_DONE,
  output logic                         O_PASS,
  output logic [15:0]                  O_ERR_COUNT,
  output logic [15:0]                  O_FIRST_ERR_ADDR
);

  localparam int               LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_SETUP  = 3'd1;
  localparam logic [2:0] S_WR_STROBE = 3'd2;
  localparam logic [2:0] S_WR_HOLD   = 3'd3;
  localparam logic [2:0] S_RD_SETUP  = 3'd4;
  localparam logic [2:0] S_RD_STROBE = 3'd5;
  localparam logic [2:0] S_RD_CHECK  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [15:0]      idx_q, idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      first_q, first_d;
  logic             we_l_q, we_l_d;
  logic             re_l_q, re_l_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             mem_en_q, mem_en_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic        locked;
  logic        last_idx;
  logic        start_ok;
  logic [15:0] cur_addr;
  logic [15:0] next_addr;

  assign locked   = (vram.I_VIDEO_MODE == 2'b11);
  assign last_idx = (idx_q == LENGTH - 16'd1);
  assign start_ok = I_START && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign cur_addr = START_ADDR + idx_q;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lat_q    <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
      first_q  <= '0;
      we_l_q   <= 1'b1;
      re_l_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      first_q  <= first_d;
      we_l_q   <= we_l_d;
      re_l_q   <= re_l_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mem_en_q <= mem_en_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (I_START) state_d = (LENGTH == 16'd0) ? S_DONE : S_WR_SETUP;
      S_WR_SETUP:     if (!locked) state_d = S_WR_STROBE;
      S_WR_STROBE:    state_d = S_WR_HOLD;
      S_WR_HOLD:      state_d = last_idx ? S_RD_SETUP : S_WR_SETUP;
      S_RD_SETUP:     if (!locked) state_d = S_RD_STROBE;
      S_RD_STROBE:    if (lat_q == LAT_LAST) state_d = S_RD_CHECK;
      S_RD_CHECK:     state_d = last_idx ? S_DONE : S_RD_SETUP;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every pin is a plain flop.
  always_comb begin
    idx_d     = idx_q;
    lat_d     = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    first_d   = first_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    next_addr = '0;

    if (start_ok) begin
      idx_d   = '0;
      err_d   = '0;
      first_d = '0;
    end

    case (state_q)
      S_WR_HOLD: idx_d = last_idx ? 16'd0 : idx_q + 16'd1;
      S_RD_STROBE: begin
        if (lat_q == LAT_LAST) rdata_d = vram.I_VRAM_DATA;
        else                   lat_d   = lat_q + LAT_W'(1);
      end
      S_RD_CHECK: begin
        if (rdata_q != (cur_addr[7:0] ^ SEED)) begin
          if (err_q == 16'd0)     first_d = cur_addr;
          if (err_q != 16'hFFFF)  err_d   = err_q + 16'd1;
        end
        if (!last_idx) idx_d = idx_q + 16'd1;
      end
      default: ;
    endcase

    next_addr = START_ADDR + idx_d;
    we_l_d    = (state_d != S_WR_STROBE);
    re_l_d    = (state_d != S_RD_STROBE);
    mem_en_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    pass_d    = (state_d == S_DONE) && (err_d == 16'd0);
    if (mem_en_d) addr_d = next_addr;
    if ((state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) || (state_d == S_WR_HOLD))
      wdata_d = next_addr[7:0] ^ SEED;
  end

  assign vram.O_MEM_ENABLE = mem_en_q;
  assign vram.O_VRAM_WE_L  = we_l_q;
  assign vram.O_VRAM_RE_L  = re_l_q;
  assign vram.O_VRAM_ADDR  = addr_q;
  assign vram.O_VRAM_DATA  = wdata_q;
  assign O_DONE            = done_q;
  assign O_PASS            = pass_q;
  assign O_ERR_COUNT       = err_q;
  assign O_FIRST_ERR_ADDR  = first_q;

endmodule
`default_nettype wire
